controle_pilha: RTL and testbench
=================================

Name: controle_pilha

Overview:
- Controller between the deserializer and the word stack. It runs entirely in the stack clock domain.
- It synchronizes the deserializer's `data_ready` flag, which arrives from the 100 kHz domain, and captures the 8-bit word.
- It pushes the word into an internal LIFO and returns a 4-phase `ack` to the deserializer.
- It also serves pop requests from the consumer side and arbitrates them against pushes.

Parameters:
- `DEPTH`, 8, number of stack entries; must be ≥ 2.
- `WIDTH`, 8, word width; matches deserializer `data_out`.
- `SYNC_STAGES`, 2, flip-flop stages on `data_ready_in`; must be ≥ 2.

Ports:
- `clock`  input  1  stack-domain clock; rising edge.
- `reset`  input  1  asynchronous, active-high reset.
- `data_ready_in`  input  1  deserializer `data_ready`; asynchronous to `clock`.
- `data_in`  input  WIDTH  deserializer `data_out`; stable while `data_ready_in` is high.
- `ack_out`  output  1  to deserializer `ack_in`; 4-phase acknowledge.
- `pop_in`  input  1  consumer pop request, level-sensitive; held until `data_valid_out`.
- `data_out`  output  WIDTH  popped word.
- `data_valid_out`  output  1  `data_out` is valid; pop acknowledge.
- `full_out`  output  1  `count_out == DEPTH`.
- `empty_out`  output  1  `count_out == 0`.
- `count_out`  output  $clog2(DEPTH+1)  current occupancy.

Behaviour:
- Reset (async, active-high):
  - state = IDLE, sp = 0, sync chain = 0.
  - `ack_out` = 0, `data_valid_out` = 0, `data_out` = 0.
  - `empty_out` = 1, `full_out` = 0, `count_out` = 0.
  - Stack array is not cleared; its contents are don't-care.
- `ready_s` = `data_ready_in` after SYNC_STAGES flops. The FSM uses only `ready_s`.
- FSM states: IDLE, CAPTURE, PUSH, ACK_WAIT, POP, POP_WAIT.
- IDLE:
  - If `pop_in` and not empty → POP. Pop has priority.
  - Else if `ready_s` and not full → CAPTURE.
  - Else stay in IDLE.
- CAPTURE: `word_reg` ← `data_in` → PUSH.
- PUSH: stack[sp] ← `word_reg`; sp ← sp+1 → ACK_WAIT.
- ACK_WAIT: hold until `ready_s` = 0, then → IDLE.
- POP: `data_out` ← stack[sp-1]; sp ← sp-1 → POP_WAIT.
- POP_WAIT: hold until `pop_in` = 0, then → IDLE.
- Outputs are Moore:
  - `ack_out` = (state == ACK_WAIT).
  - `data_valid_out` = (state == POP_WAIT).
  - `full_out`, `empty_out` and `count_out` are decoded from the registered sp.
  - `data_out` holds its last popped value until the next POP.
- Push latency: with SYNC_STAGES = 2, `ack_out` rises on the 5th rising edge after `data_ready_in` rises, with ±1 edge of synchronizer uncertainty.
- Pop latency: `data_valid_out` rises 2 edges after `pop_in` is sampled high in IDLE.
- Full with `ready_s` high: no capture and no ack. The deserializer stays stalled (backpressure) until a pop frees an entry.
- Empty with `pop_in` high: ignored and no response. The consumer must qualify requests with `empty_out`.
- `ready_s` and `pop_in` both high in IDLE with the stack neither empty nor full:
  - The pop completes first.
  - The push starts in the first IDLE cycle after `pop_in` drops.
- Full, then pop, then pending push: sp goes DEPTH → DEPTH-1 → DEPTH. No overflow.
- sp never wraps. Push is illegal when sp == DEPTH and pop when sp == 0; the FSM guards both.
- Reset mid-handshake: `ack_out` drops immediately (async).
  - If reset hits in CAPTURE or PUSH, that word is lost.
  - The deserializer is responsible for its own reset.
- `pop_in` and `ready_s` changes while in a non-IDLE state have no effect, except the exit conditions of ACK_WAIT and POP_WAIT.

Decomposition:
- Package `pilha_pkg`:
  - state enum `estado_t`.
  - `WIDTH` default.
  - the `count_out` width function.
- Sub-module `sincronizador`: SYNC_STAGES-deep flop chain with asynchronous active-high reset to 0. It is reused for any other cross-domain flag.
- Stack storage and FSM stay inline in `controle_pilha`.

Test Plan:
- Single push: `data_in` = 8'hA5, `data_ready_in` raised → `ack_out` high ~5 edges later. Drop `data_ready_in` → `ack_out` low 3 edges later; `count_out` = 1.
- Push 8'h11, 8'h22, 8'h33, then three pops → `data_out` sequence 33, 22, 11, each with one `data_valid_out` handshake; `empty_out` = 1 at end.
- Fill to DEPTH = 8, then raise `data_ready_in` → no `ack_out` and `full_out` = 1. Then pop once → `ack_out` rises; `count_out` 8 → 7 → 8.
- Raise `pop_in` and `data_ready_in` in the same cycle with `count_out` = 2 → POP serviced first, returning the top word. The push follows after `pop_in` drops; final `count_out` = 2.
- `pop_in` with `empty_out` = 1 → `data_valid_out` stays 0 for 20 cycles; state stays IDLE.
- Assert `reset` while in ACK_WAIT → `ack_out` = 0 immediately, `count_out` = 0, `empty_out` = 1. A fresh push of 8'h5C afterwards works.

Source files
------------

// File: rtl/pilha_pkg.sv
// Shared types and sizing helpers for the word-stack controller.
package pilha_pkg;

  localparam int WIDTH_PADRAO = 8;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_CAPTURE  = 3'd1,
    ST_PUSH     = 3'd2,
    ST_ACK_WAIT = 3'd3,
    ST_POP      = 3'd4,
    ST_POP_WAIT = 3'd5
  } estado_t;

  // Occupancy must represent 0..DEPTH inclusive.
  function automatic int largura_contagem(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/sincronizador.sv
// Multi-flop synchronizer for a single asynchronous flag, cleared to 0 on reset.
module sincronizador #(
  parameter int STAGES = 2
) (
  input  logic clock,
  input  logic reset,
  input  logic async_in,
  output logic sync_out
);

  logic [STAGES-1:0] chain_q;

  // Shift the flag through the chain; only the last stage is consumed.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      chain_q <= '0;
    end else begin
      chain_q <= {chain_q[STAGES-2:0], async_in};
    end
  end

  assign sync_out = chain_q[STAGES-1];

endmodule

// File: rtl/controle_pilha.sv
// Deserializer-to-stack controller: synchronized push with 4-phase ack, level pop,
// pop has priority over push; both are guarded against overflow/underflow.
module controle_pilha
  import pilha_pkg::*;
#(
  parameter int DEPTH       = 8,
  parameter int WIDTH       = WIDTH_PADRAO,
  parameter int SYNC_STAGES = 2
) (
  input  logic                               clock,
  input  logic                               reset,
  input  logic                               data_ready_in,
  input  logic [WIDTH-1:0]                   data_in,
  output logic                               ack_out,
  input  logic                               pop_in,
  output logic [WIDTH-1:0]                   data_out,
  output logic                               data_valid_out,
  output logic                               full_out,
  output logic                               empty_out,
  output logic [largura_contagem(DEPTH)-1:0] count_out
);

  localparam int CW = largura_contagem(DEPTH);
  localparam int AW = $clog2(DEPTH);
  localparam logic [CW-1:0] SP_FULL = CW'(DEPTH);

  estado_t          state_q, state_d;
  logic [CW-1:0]    sp_q, sp_d;
  logic [WIDTH-1:0] word_q, word_d;
  logic [WIDTH-1:0] dout_q, dout_d;
  logic [WIDTH-1:0] pilha_q [DEPTH];

  logic          ready_s;
  logic          full_s;
  logic          empty_s;
  logic [CW-1:0] sp_m1_s;

  sincronizador #(
    .STAGES (SYNC_STAGES)
  ) u_sync_ready (
    .clock    (clock),
    .reset    (reset),
    .async_in (data_ready_in),
    .sync_out (ready_s)
  );

  assign full_s  = (sp_q == SP_FULL);
  assign empty_s = (sp_q == {CW{1'b0}});
  assign sp_m1_s = sp_q - CW'(1);

  // Next-state and datapath decisions; pop wins when both requests are pending.
  always_comb begin
    state_d = state_q;
    sp_d    = sp_q;
    word_d  = word_q;
    dout_d  = dout_q;
    case (state_q)
      ST_IDLE: begin
        if (pop_in && !empty_s) begin
          state_d = ST_POP;
        end else if (ready_s && !full_s) begin
          state_d = ST_CAPTURE;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_CAPTURE: begin
        word_d  = data_in;
        state_d = ST_PUSH;
      end
      ST_PUSH: begin
        sp_d    = sp_q + CW'(1);
        state_d = ST_ACK_WAIT;
      end
      ST_ACK_WAIT: begin
        if (!ready_s) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_ACK_WAIT;
        end
      end
      ST_POP: begin
        dout_d  = pilha_q[sp_m1_s[AW-1:0]];
        sp_d    = sp_m1_s;
        state_d = ST_POP_WAIT;
      end
      ST_POP_WAIT: begin
        if (!pop_in) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_POP_WAIT;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Control state, stack pointer and word registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      sp_q    <= '0;
      word_q  <= '0;
      dout_q  <= '0;
    end else begin
      state_q <= state_d;
      sp_q    <= sp_d;
      word_q  <= word_d;
      dout_q  <= dout_d;
    end
  end

  // Stack storage is deliberately left uncleared by reset.
  always_ff @(posedge clock) begin
    if (state_q == ST_PUSH) begin
      pilha_q[sp_q[AW-1:0]] <= word_q;
    end
  end

  assign ack_out        = (state_q == ST_ACK_WAIT);
  assign data_valid_out = (state_q == ST_POP_WAIT);
  assign data_out       = dout_q;
  assign full_out       = full_s;
  assign empty_out      = empty_s;
  assign count_out      = sp_q;

endmodule

// File: tb/tb_controle_pilha.sv
// Directed bench for controle_pilha: latencies, LIFO order, full/empty guards, reset.
module tb_controle_pilha;

  logic       clock;
  logic       reset;
  logic       data_ready_in;
  logic [7:0] data_in;
  logic       ack_out;
  logic       pop_in;
  logic [7:0] data_out;
  logic       data_valid_out;
  logic       full_out;
  logic       empty_out;
  logic [3:0] count_out;

  int total;
  int bad;

  controle_pilha #(.DEPTH(8), .WIDTH(8), .SYNC_STAGES(2)) dut (
    .clock          (clock),
    .reset          (reset),
    .data_ready_in  (data_ready_in),
    .data_in        (data_in),
    .ack_out        (ack_out),
    .pop_in         (pop_in),
    .data_out       (data_out),
    .data_valid_out (data_valid_out),
    .full_out       (full_out),
    .empty_out      (empty_out),
    .count_out      (count_out)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Push one word; checks ack rise latency, fall latency and resulting count.
  task automatic do_push(input logic [7:0] w, input int exp_cnt);
    int n;
    @(negedge clock);
    data_in       = w;
    data_ready_in = 1'b1;
    n = 0;
    while (!ack_out && n < 20) begin
      @(negedge clock);
      n++;
    end
    chk("push_ack_lat", n, 5);
    chk("push_count", count_out, exp_cnt);
    data_ready_in = 1'b0;
    n = 0;
    while (ack_out && n < 20) begin
      @(negedge clock);
      n++;
    end
    chk("push_ack_drop_lat", n, 3);
  endtask

  // Pop one word; checks valid latency, returned word and release.
  task automatic do_pop(input logic [7:0] exp_w, input int exp_cnt);
    int n;
    @(negedge clock);
    pop_in = 1'b1;
    n = 0;
    while (!data_valid_out && n < 20) begin
      @(negedge clock);
      n++;
    end
    chk("pop_valid_lat", n, 2);
    chk("pop_data", data_out, exp_w);
    chk("pop_count", count_out, exp_cnt);
    pop_in = 1'b0;
    n = 0;
    while (data_valid_out && n < 20) begin
      @(negedge clock);
      n++;
    end
    chk("pop_release_lat", n, 1);
  endtask

  initial begin
    int n;
    int hits;
    total = 0;
    bad   = 0;
    reset = 1'b1;
    data_ready_in = 1'b0;
    data_in = 8'h00;
    pop_in  = 1'b0;
    #12;
    chk("rst_ack", ack_out, 0);
    chk("rst_valid", data_valid_out, 0);
    chk("rst_dout", data_out, 0);
    chk("rst_empty", empty_out, 1);
    chk("rst_full", full_out, 0);
    chk("rst_count", count_out, 0);
    @(negedge clock);
    reset = 1'b0;

    // Single push, then take it back out.
    do_push(8'hA5, 1);
    do_pop(8'hA5, 0);

    // LIFO order.
    do_push(8'h11, 1);
    do_push(8'h22, 2);
    do_push(8'h33, 3);
    do_pop(8'h33, 2);
    do_pop(8'h22, 1);
    do_pop(8'h11, 0);
    chk("lifo_empty", empty_out, 1);

    // Fill to capacity.
    for (int i = 0; i < 8; i++) begin
      do_push(8'h10 + 8'(i), i + 1);
    end
    chk("full_flag", full_out, 1);
    chk("full_count", count_out, 8);

    // Backpressure: a pending push while full gets no ack.
    @(negedge clock);
    data_in = 8'hEE;
    data_ready_in = 1'b1;
    hits = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clock);
      if (ack_out) hits++;
    end
    chk("full_no_ack", hits, 0);
    chk("full_count_hold", count_out, 8);

    // One pop frees an entry; the stalled push then completes.
    pop_in = 1'b1;
    n = 0;
    while (!data_valid_out && n < 20) begin
      @(negedge clock);
      n++;
    end
    chk("full_pop_lat", n, 2);
    chk("full_pop_data", data_out, 8'h17);
    chk("full_pop_count", count_out, 7);
    pop_in = 1'b0;
    n = 0;
    while (!ack_out && n < 20) begin
      @(negedge clock);
      n++;
    end
    chk("refill_ack_lat", n, 4);
    chk("refill_count", count_out, 8);
    chk("refill_full", full_out, 1);
    data_ready_in = 1'b0;
    n = 0;
    while (ack_out && n < 20) begin
      @(negedge clock);
      n++;
    end
    chk("refill_drop_lat", n, 3);

    do_pop(8'hEE, 7);
    for (int i = 6; i >= 2; i--) begin
      do_pop(8'h10 + 8'(i), i);
    end
    chk("two_left", count_out, 2);

    // Simultaneous pop and push requests: pop is serviced first.
    @(negedge clock);
    pop_in = 1'b1;
    data_ready_in = 1'b1;
    data_in = 8'h77;
    n = 0;
    while (!data_valid_out && n < 20) begin
      @(negedge clock);
      n++;
    end
    chk("arb_pop_lat", n, 2);
    chk("arb_pop_data", data_out, 8'h11);
    hits = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clock);
      if (ack_out) hits++;
    end
    chk("arb_no_ack_while_pop", hits, 0);
    chk("arb_count_mid", count_out, 1);
    pop_in = 1'b0;
    n = 0;
    while (!ack_out && n < 20) begin
      @(negedge clock);
      n++;
    end
    chk("arb_push_lat", n, 4);
    chk("arb_count_final", count_out, 2);
    data_ready_in = 1'b0;
    repeat (4) @(negedge clock);
    do_pop(8'h77, 1);
    do_pop(8'h10, 0);

    // Pop on empty is ignored.
    pop_in = 1'b1;
    hits = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clock);
      if (data_valid_out) hits++;
    end
    chk("empty_no_valid", hits, 0);
    chk("empty_count", count_out, 0);
    chk("empty_flag", empty_out, 1);
    pop_in = 1'b0;

    // Reset during ACK_WAIT, then a fresh push.
    do_push(8'h42, 1);
    @(negedge clock);
    data_in = 8'h99;
    data_ready_in = 1'b1;
    n = 0;
    while (!ack_out && n < 20) begin
      @(negedge clock);
      n++;
    end
    chk("pre_rst_ack", ack_out, 1);
    #2;
    reset = 1'b1;
    #1;
    chk("midrst_ack", ack_out, 0);
    chk("midrst_count", count_out, 0);
    chk("midrst_empty", empty_out, 1);
    chk("midrst_dout", data_out, 0);
    data_ready_in = 1'b0;
    repeat (2) @(negedge clock);
    reset = 1'b0;
    repeat (2) @(negedge clock);
    do_push(8'h5C, 1);
    do_pop(8'h5C, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
